frame_reverse_mem: RTL and testbench
====================================

# frame_reverse_mem

Block-reversal buffer. It accepts a stream of `DW`-bit samples under a clock enable and re-emits each consecutive block of `LEN` samples in reverse order, exactly one block later. It uses a two-bank (ping-pong) memory and shares the enable-gated streaming interface of the delay-chain memory blocks. It is the read-order inverse of a FIFO delay line: the stream-reversal stage used ahead of time-reversed filtering and bit-reversal reorder paths.

## Interface
- `DW`, default 8: sample width in bits.
- `LEN`, default 5: block length in samples; legal range is 2 or more, and it need not be a power of two.
- `AW`, default `$clog2(LEN)`: address/counter width. Derived; not overridden.

Ports:
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  clock enable; all state advances only on edges where `en`=1.
- `din`  input  DW  input sample, captured on enabled edges.
- `dout`  output  DW  reversed output sample, registered.
- `dout_valid`  output  1  `dout` carries a real reversed sample.
- `dout_first`  output  1  `dout` carries the first sample of a reversed block (the last sample of that input block).

## Operation
State:
- Memory `mem[2][LEN]` of DW-bit words; not reset.
- `wcnt` (AW bits), range 0..LEN-1.
- `wbank` (1 bit).
- `primed` (1 bit).

On each enabled edge:
- Write: `mem[wbank][wcnt] <= din`.
- Read: `mem[~wbank][LEN-1-wcnt]` is read combinationally and registered into `dout`. The read and write banks always differ, so there is no read/write collision.
- Counter: if `wcnt == LEN-1`, then `wcnt <= 0`, `wbank <= ~wbank`, and `primed <= 1`. Otherwise `wcnt <= wcnt+1`.
- Output gating: `dout_valid <= primed` and `dout_first <= primed & (wcnt == 0)`. If `primed` = 0, `dout <= 0` regardless of memory contents, so no X propagates.

On edges where `en`=0:
- All registers hold, including `dout`, `dout_valid` and `dout_first`.
- Memory is not written.

Counter arithmetic:
- `wcnt` wraps explicitly at LEN-1, never by natural overflow; this is required for non-power-of-two `LEN`.
- The read address `LEN-1-wcnt` is computed in AW bits and never underflows.

Reset (asynchronous, at any time, including mid-block):
- `wcnt`=0, `wbank`=0, `primed`=0, `dout`=0, `dout_valid`=0, `dout_first`=0.
- After reset deassertion, the first complete block must be written again before any output is valid. Stale memory contents are never emitted.

## Timing
- Enabled edges are numbered e0, e1, … after reset.
- Sample k of block n (0 ≤ k < LEN) is written at edge e(n·LEN+k).
- That sample appears on `dout` immediately after edge e((n+1)·LEN + LEN-1-k).
- Latency in enabled edges is therefore 2·(LEN-1-k)+1. For k = LEN-1 this is 1 edge; for k = 0 it is 2·LEN-1 edges.
- `primed` rises at edge e(LEN-1).
- `dout_valid` rises after edge e(LEN) and stays high until reset.
- `dout_first` pulses after edges e(LEN), e(2·LEN), …. Each pulse lasts one enabled edge, and it holds across disabled cycles.
- Throughput is one sample per enabled edge, continuous, with no bubbles at block boundaries.
- Disabled cycles stretch the timeline but never reorder, drop or duplicate samples.

## Test plan
LEN=5, DW=8 unless stated otherwise.

1. Reset hold, then `en`=1 continuously with `din` = 1,2,3,…,15. Required: `dout` = 0 and `dout_valid` = 0 through e4. After e5..e9, `dout` = 5,4,3,2,1; after e10..e14, `dout` = 10,9,8,7,6. `dout_first` is high only after e5 and e10.
2. Same stream with `en` dropped for 2 cycles after e2, and again for 3 cycles after e7. Required: the enabled-edge output sequence is identical to scenario 1, and `dout`, `dout_valid` and `dout_first` are frozen during the gaps.
3. Assert `rst_n` = 0 asynchronously (not edge-aligned) after e7, then restart the stream with 101..110. Required: all outputs are 0 immediately on reset. After the restart, `dout` stays 0 and invalid through the new e4, then shows 105,104,103,102,101. Data from before the reset must never appear.
4. LEN=6 (non-power-of-two), `din` = 0x10..0x1B continuous. Required: `dout` = 0x15..0x10 after e6..e11, and `wcnt` never exceeds 5.
5. LEN=2, a long random stream, checked against a scoreboard model that reverses each pair. Required: zero mismatches over 200 enabled edges, with `dout_first` on every second valid edge.
6. Random `en` (50 %) with random `din` at LEN=5, checked against the same block-reverse reference model indexed by enabled edges. Required: zero mismatches over 400 cycles.

Source files
------------

// File: rtl/frame_reverse_mem.sv
// frame_reverse_mem: block-reversal buffer.
// Each block of LEN samples written into one bank is read back in reverse
// order from the other bank while the next block is written. The output is
// therefore delayed by exactly one block. All state advances only when en=1.
`timescale 1ns/1ps

module frame_reverse_mem #(
  parameter int DW  = 8,
  parameter int LEN = 5,
  parameter int AW  = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          dout_first
);

  // Index of the last sample in a block. The counter wraps here explicitly,
  // so non-power-of-two block lengths never see the unused counter codes.
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  // Ping-pong sample storage. Deliberately not reset: the primed flag keeps
  // stale contents from ever reaching dout.
  logic [DW-1:0] mem [0:1][0:LEN-1];

  // Write-side control
  logic [AW-1:0] wcnt;
  logic          wbank;
  logic          primed;

  // Read-side combinational signals
  logic          wrap;
  logic          rbank;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata_p0;
  logic          first_p0;

  // Read address mirrors the write address inside the opposite bank, so the
  // two banks never collide and the previous block comes out reversed.
  always_comb begin
    wrap     = (wcnt == LAST);
    rbank    = ~wbank;
    raddr    = LAST - wcnt;
    rdata_p0 = mem[rbank][raddr];
    first_p0 = primed & (wcnt == '0);
  end

  // Sample write into the active bank on enabled edges only.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[wbank][wcnt] <= din;
    end
  end

  // Write counter, bank toggle and primed flag; primed sets once the first
  // complete block is in memory and stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= '0;
      wbank  <= 1'b0;
      primed <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        wcnt   <= '0;
        wbank  <= ~wbank;
        primed <= 1'b1;
      end else begin
        wcnt   <= wcnt + 1'b1;
      end
    end
  end

  // ---- stage p0 -> output register ----
  // Output register; data is forced to zero until primed so no uninitialised
  // memory word is ever visible. Everything holds when en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
    end else if (en) begin
      dout       <= primed ? rdata_p0 : '0;
      dout_valid <= primed;
      dout_first <= first_p0;
    end
  end

endmodule

// File: tb/tb_frame_reverse_mem.sv
// Testbench for frame_reverse_mem: three instances (LEN=5, LEN=6, LEN=2),
// directed hand-tabled streams plus a block-reverse reference model, with a
// queue-based scoreboard popped by per-instance monitors.
`timescale 1ns/1ps

module tb_frame_reverse_mem;

  typedef struct packed {
    logic       v;
    logic       f;
    logic [7:0] d;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en5 = 1'b0, en6 = 1'b0, en2 = 1'b0;
  logic [7:0] din5 = '0, din6 = '0, din2 = '0;
  logic [7:0] dout5, dout6, dout2;
  logic v5, f5, v6, f6, v2, f2;

  int n_cmp = 0;
  int n_fail = 0;

  obs_t q5[$], q6[$], q2[$];
  obs_t last5 = '0, last6 = '0, last2 = '0;

  logic [7:0] hist [0:1023];
  int model_e = 0;

  // Hand-computed output of LEN=5 for din = 1..15, one entry per enabled edge.
  logic [7:0] s1_exp [0:14] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                                8'd5, 8'd4, 8'd3, 8'd2, 8'd1,
                                8'd10, 8'd9, 8'd8, 8'd7, 8'd6};

  frame_reverse_mem #(.DW(8), .LEN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .din(din5),
    .dout(dout5), .dout_valid(v5), .dout_first(f5));

  frame_reverse_mem #(.DW(8), .LEN(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en6), .din(din6),
    .dout(dout6), .dout_valid(v6), .dout_first(f6));

  frame_reverse_mem #(.DW(8), .LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .din(din2),
    .dout(dout2), .dout_valid(v2), .dout_first(f2));

  always #5 clk = ~clk;

  task automatic check(string name, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%0b f=%0b d=0x%02h, required v=%0b f=%0b d=0x%02h",
               name, act.v, act.f, act.d, exp.v, exp.f, exp.d);
    end
  endtask

  task automatic underflow(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got output edge with empty queue, required a queued expectation", name);
  endtask

  // Monitor LEN=5: pop on enabled edges, expect frozen outputs otherwise.
  logic m5_en, m5_rst;
  obs_t m5_exp;
  always @(posedge clk) begin
    m5_en = en5;
    m5_rst = rst_n;
    #1;
    if (!m5_rst) m5_exp = '0;
    else if (m5_en) begin
      if (q5.size() == 0) begin underflow("dut5_queue"); m5_exp = last5; end
      else m5_exp = q5.pop_front();
    end else m5_exp = last5;
    check($sformatf("dut5_out(en=%0b)", m5_en), {v5, f5, dout5}, m5_exp);
    last5 = m5_exp;
  end

  // Monitor LEN=6, also bounds the internal write counter.
  logic m6_en, m6_rst;
  obs_t m6_exp;
  always @(posedge clk) begin
    m6_en = en6;
    m6_rst = rst_n;
    #1;
    if (!m6_rst) m6_exp = '0;
    else if (m6_en) begin
      if (q6.size() == 0) begin underflow("dut6_queue"); m6_exp = last6; end
      else m6_exp = q6.pop_front();
      n_cmp++;
      if (dut6.wcnt > 3'd5) begin
        n_fail++;
        $display("FAIL dut6_wcnt: got %0d, required <= 5", dut6.wcnt);
      end
    end else m6_exp = last6;
    check($sformatf("dut6_out(en=%0b)", m6_en), {v6, f6, dout6}, m6_exp);
    last6 = m6_exp;
  end

  // Monitor LEN=2.
  logic m2_en, m2_rst;
  obs_t m2_exp;
  always @(posedge clk) begin
    m2_en = en2;
    m2_rst = rst_n;
    #1;
    if (!m2_rst) m2_exp = '0;
    else if (m2_en) begin
      if (q2.size() == 0) begin underflow("dut2_queue"); m2_exp = last2; end
      else m2_exp = q2.pop_front();
    end else m2_exp = last2;
    check($sformatf("dut2_out(en=%0b)", m2_en), {v2, f2, dout2}, m2_exp);
    last2 = m2_exp;
  end

  task automatic push(int id, logic v, logic f, logic [7:0] d);
    obs_t o;
    o = {v, f, d};
    case (id)
      5:       q5.push_back(o);
      6:       q6.push_back(o);
      default: q2.push_back(o);
    endcase
  endtask

  task automatic drive(int id, logic [7:0] d);
    @(negedge clk);
    en5 = (id == 5);
    en6 = (id == 6);
    en2 = (id == 2);
    case (id)
      5:       din5 = d;
      6:       din6 = d;
      default: din2 = d;
    endcase
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      en5 = 1'b0;
      en6 = 1'b0;
      en2 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en5 = 1'b0;
    en6 = 1'b0;
    en2 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: output after enabled edge e is input sample
  // (e/len)*len - 1 - (e%len), i.e. the previous block read backwards.
  task automatic model(int id, int len, logic [7:0] d);
    int j, src;
    hist[model_e] = d;
    if (model_e < len) push(id, 1'b0, 1'b0, 8'd0);
    else begin
      j = model_e % len;
      src = (model_e / len) * len - 1 - j;
      push(id, 1'b1, (j == 0), hist[src]);
    end
    model_e++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: continuous stream 1..15.
    for (int i = 0; i < 15; i++) begin
      drive(5, 8'(i + 1));
      push(5, i >= 5, (i == 5) || (i == 10), s1_exp[i]);
    end
    idle(2);

    // Scenario 2: same stream with enable gaps after e2 and e7.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(5, 8'(i + 1));
      push(5, i >= 5, (i == 5) || (i == 10), s1_exp[i]);
      if (i == 2) idle(2);
      if (i == 7) idle(3);
    end
    idle(2);

    // Scenario 3: asynchronous reset mid-block, then restart with 101..110.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(5, 8'(i + 1));
      push(5, i >= 5, i == 5, s1_exp[i]);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en5 = 1'b0;
    #1;
    check("async_reset_dut5", {v5, f5, dout5}, '0);
    check("async_reset_dut6", {v6, f6, dout6}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(5, 8'(101 + i));
      push(5, i >= 5, i == 5, (i >= 5) ? 8'(105 - (i - 5)) : 8'd0);
    end
    idle(2);

    // Scenario 4: LEN=6, din 0x10..0x1B.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(6, 8'(8'h10 + i));
      push(6, i >= 6, i == 6, (i >= 6) ? 8'(8'h15 - (i - 6)) : 8'd0);
    end
    idle(2);

    // Scenario 5: LEN=2, 200 random enabled edges.
    do_reset();
    model_e = 0;
    for (int i = 0; i < 200; i++) begin
      r = 8'($urandom);
      drive(2, r);
      model(2, 2, r);
    end
    idle(2);

    // Scenario 6: LEN=5, random enable over 400 cycles.
    do_reset();
    model_e = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        r = 8'($urandom);
        drive(5, r);
        model(5, 5, r);
      end else begin
        idle(1);
      end
    end
    idle(3);

    n_cmp++;
    if (q5.size() + q6.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: got %0d pending, required 0",
               q5.size() + q6.size() + q2.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
